// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Fetch/decode/execute sequencer for the 4-bit CPU. It holds the PC,
//   the instruction register, the accumulator and the {Z,N,C,V} flag
//   register. Instructions come from an asynchronous program ROM, and the
//   sequencer drives the downstream ALU.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse that leaves IDLE
//   instr_addr   program ROM address (the PC)
//   instr_data   ROM data: [7:4] opcode, [3:0] immediate
//   alu_a        ALU operand A (accumulator)
//   alu_b        ALU operand B (IR immediate)
//   alu_opcode   ALU opcode (IR opcode)
//   alu_en       ALU enable, high only in EXECUTE
//   alu_result   ALU result, captured at the end of EXECUTE
//   alu_zero / alu_negative / alu_carry / alu_overflow   ALU flags
//   acc_out      accumulator
//   flags_out    {Z,N,C,V}
//   halted       high while in HALT
module cpu_control_unit #(
  parameter int unsigned PC_WIDTH = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [PC_WIDTH-1:0] instr_addr,
  input  logic [7:0]          instr_data,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic [3:0]          alu_opcode,
  output logic                alu_en,
  input  logic [3:0]          alu_result,
  input  logic                alu_zero,
  input  logic                alu_negative,
  input  logic                alu_carry,
  input  logic                alu_overflow,
  output logic [3:0]          acc_out,
  output logic [3:0]          flags_out,
  output logic                halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    HALT
  } state_t;

  // Flag register bit positions within {Z,N,C,V}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next;
  logic [7:0]          ir, ir_next;
  logic [3:0]          acc, acc_next;
  logic [3:0]          flags, flags_next;

  logic [3:0]          ir_op;
  logic [3:0]          ir_imm;
  logic [PC_WIDTH-1:0] imm_pc;

  assign ir_op  = ir[7:4];
  assign ir_imm = ir[3:0];
  assign imm_pc = PC_WIDTH'(ir_imm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= PC_WIDTH'(RESET_PC);
      ir    <= '0;
      acc   <= '0;
      flags <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      acc   <= acc_next;
      flags <= flags_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    acc_next   = acc;
    flags_next = flags;

    unique case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end

      FETCH: begin
        ir_next    = instr_data;
        // Natural modulo-2^PC_WIDTH wrap
        pc_next    = pc + PC_WIDTH'(1);
        state_next = DECODE;
      end

      DECODE: begin
        state_next = FETCH;
        if (ir_op[3]) begin
          state_next = EXECUTE;
        end else begin
          case (ir_op[2:0])
            3'd1: begin
              acc_next           = ir_imm;
              flags_next[FLAG_Z] = (ir_imm == 4'd0);
              flags_next[FLAG_N] = ir_imm[3];
            end
            3'd2: pc_next = imm_pc;
            3'd3: if (flags[FLAG_Z]) pc_next = imm_pc;
            3'd4: if (flags[FLAG_C]) pc_next = imm_pc;
            3'd7: state_next = HALT;
            // NOP and the reserved codes fall through to FETCH
            default: ;
          endcase
        end
      end

      EXECUTE: begin
        acc_next   = alu_result;
        flags_next = {alu_zero, alu_negative, alu_carry, alu_overflow};
        state_next = FETCH;
      end

      HALT: ;

      default: state_next = IDLE;
    endcase
  end

  assign instr_addr = pc;
  assign alu_a      = acc;
  assign alu_b      = ir_imm;
  assign alu_opcode = ir_op;
  assign alu_en     = (state == EXECUTE);
  assign acc_out    = acc;
  assign flags_out  = flags;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: ROM and ALU environment, an
// instruction-level reference interpreter feeding a scoreboard queue of
// expected ALU transactions, and a monitor that pops on every alu_en cycle.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [3:0] alu_a, alu_b, alu_opcode;
  logic       alu_en;
  logic [3:0] alu_result;
  logic       alu_zero, alu_negative, alu_carry, alu_overflow;
  logic [3:0] acc_out, flags_out;
  logic       halted;

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_WIDTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_en(alu_en),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .acc_out(acc_out), .flags_out(flags_out), .halted(halted)
  );

  logic [7:0] rom [16];
  assign instr_data = rom[instr_addr];

  // Environment ALU: returns {Z,N,C,V,result}
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = 4'd0; s = 5'd0;
    case (op)
      4'h8: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                  v = (a[3] == b[3]) && (r[3] != a[3]); end
      4'h9: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                  v = (a[3] != b[3]) && (r[3] != a[3]); end
      4'hA: r = a & b;
      4'hB: r = a | b;
      4'hC: r = a ^ b;
      4'hD: r = ~a;
      4'hE: begin r = a << 1; c = a[3]; end
      4'hF: begin r = a >> 1; c = a[0]; end
      default: r = 4'd0;
    endcase
    return {(r == 4'd0), r[3], c, v, r};
  endfunction

  always_comb begin
    {alu_zero, alu_negative, alu_carry, alu_overflow, alu_result} = alu_ref(alu_opcode, alu_a, alu_b);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] acc;
    logic [3:0] flags;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur, pend_item;
  logic pend = 1'b0;
  logic mon_en = 1'b0;

  // Monitor: every cycle with alu_en must match the next expected ALU op;
  // the accumulator/flags are checked one cycle later.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (pend) begin
        check("alu_acc", acc_out, pend_item.acc);
        check("alu_flags", flags_out, pend_item.flags);
        pend = 1'b0;
      end
      if (alu_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_alu_en", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("alu_opcode", alu_opcode, cur.op);
          check("alu_a", alu_a, cur.a);
          check("alu_b", alu_b, cur.b);
          pend_item = cur;
          pend = 1'b1;
        end
      end
    end
  end

  // Instruction-level reference interpreter
  logic [3:0] m_pc, m_acc, m_flags;
  logic       m_halted;
  int         m_cycles;

  task automatic model_run(input int max_instr);
    logic [7:0] ins;
    logic [7:0] res;
    exp_t e;
    m_pc = 4'd0; m_acc = 4'd0; m_flags = 4'd0; m_halted = 1'b0; m_cycles = 0;
    for (int n = 0; n < max_instr; n++) begin
      ins  = rom[m_pc];
      m_pc = m_pc + 4'd1;
      if (ins[7]) begin
        res = alu_ref(ins[7:4], m_acc, ins[3:0]);
        e.op = ins[7:4]; e.a = m_acc; e.b = ins[3:0];
        e.acc = res[3:0]; e.flags = res[7:4];
        exp_q.push_back(e);
        m_acc = res[3:0]; m_flags = res[7:4];
        m_cycles += 3;
      end else begin
        m_cycles += 2;
        case (ins[7:4])
          4'h1: begin m_acc = ins[3:0]; m_flags[3] = (ins[3:0] == 4'd0); m_flags[2] = ins[3]; end
          4'h2: m_pc = ins[3:0];
          4'h3: if (m_flags[3]) m_pc = ins[3:0];
          4'h4: if (m_flags[1]) m_pc = ins[3:0];
          4'h7: m_halted = 1'b1;
          default: ;
        endcase
        if (m_halted) break;
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    start  = 1'b0;
    rst_n  = 1'b0;
    pend   = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc_out, 0);
    check("rst_flags", flags_out, 0);
    check("rst_pc", instr_addr, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_halted", halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs the current ROM for max_instr instructions (or until HLT) and
  // compares the architectural state at that instruction boundary.
  task automatic run_program(input int max_instr, input bit rand_start);
    int first_halt;
    int last;
    do_reset();
    model_run(max_instr);
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    first_halt = -1;
    last = m_halted ? m_cycles + 4 : m_cycles;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      if (halted && first_halt < 0) first_halt = c;
      if (c == m_cycles || c == last) begin
        check("acc", acc_out, m_acc);
        check("flags", flags_out, m_flags);
        check("pc", instr_addr, m_pc);
        check("halted", halted, m_halted);
      end
    end
    if (m_halted) check("halt_latency", first_halt, m_cycles);
    @(negedge clk);
    start = 1'b0;
    #1;
    mon_en = 1'b0;
    check("alu_ops_left", exp_q.size(), 0);
  endtask

  task automatic fill_rom(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) rom[i] = fill;
  endtask

  initial begin
    fill_rom(8'h70);

    // LDI 2; ADD 3; HLT
    fill_rom(8'h70);
    rom[0] = 8'h12; rom[1] = 8'h83; rom[2] = 8'h70;
    run_program(50, 1'b0);

    // LDI 7; ADD 4; HLT -> overflow into negative
    fill_rom(8'h70);
    rom[0] = 8'h17; rom[1] = 8'h84; rom[2] = 8'h70;
    run_program(50, 1'b0);

    // LDI 1; SUB 1; JZ 5; LDI 15; HLT; LDI 9; HLT
    fill_rom(8'h70);
    rom[0] = 8'h11; rom[1] = 8'h91; rom[2] = 8'h35; rom[3] = 8'h1F;
    rom[4] = 8'h70; rom[5] = 8'h19; rom[6] = 8'h70;
    run_program(50, 1'b1);

    // PC wrap: NOPs up to 14, LDI 6 at 15, then back to address 0
    fill_rom(8'h00);
    rom[15] = 8'h16;
    run_program(16, 1'b1);

    // LDI 15; ADD 1; JC 0 loop, then reset in the middle of EXECUTE
    fill_rom(8'h70);
    rom[0] = 8'h1F; rom[1] = 8'h81; rom[2] = 8'h40;
    run_program(4, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (alu_en) seen = 1'b1;
      end
      check("abort_alu_en_seen", seen, 1);
      check("abort_acc_before", acc_out, 4'hF);
      rst_n = 1'b0;
      #1;
      check("abort_acc", acc_out, 0);
      check("abort_flags", flags_out, 0);
      check("abort_alu_en", alu_en, 0);
      check("abort_pc", instr_addr, 0);
      check("abort_halted", halted, 0);
      @(posedge clk);
      #1;
      check("abort_acc_held", acc_out, 0);
    end

    // Randomized programs with random start pulses during execution
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) op = 4'h7;
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      run_program(30, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
